// File: rtl/axi_stride_reader.sv
// axi_stride_reader
//   AXI read-address master that issues a programmed stream of strided AR
//   requests (base, stride, count, inter-request gap) and sinks the R channel.
//   It tracks outstanding bursts, flags R-channel anomalies and reports the
//   number of cycles a run took.
// Ports
//   clk, resetN            clock (rising edge), asynchronous active-low reset
//   start                  launch a run; only sampled while idle
//   cfg_*                  run configuration, latched when start is accepted
//   m_ar_*                 AR channel (valid/addr/len/id out, ready in)
//   m_r_*                  R channel (valid/last/id in, ready out)
//   busy, done             run in progress / one-cycle completion pulse
//   err_id, err_unexp      sticky R anomalies: wrong id, beat with nothing outstanding
//   outstanding            AR handshakes minus R-last handshakes
//   run_cycles             cycles spent in ISSUE/GAP/DRAIN, saturating
module axi_stride_reader #(
  parameter int ADDR_BITS       = 16,
  parameter int BURST_LEN_WIDTH = 8,
  parameter int TID_WIDTH       = 8,
  parameter int CNT_WIDTH       = 8,
  parameter int GAP_WIDTH       = 8,
  parameter int LOG_MAX_OUT     = 3,
  parameter int CYC_WIDTH       = 24
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       start,
  input  logic [ADDR_BITS-1:0]       cfg_base,
  input  logic [ADDR_BITS-1:0]       cfg_stride,
  input  logic [CNT_WIDTH-1:0]       cfg_count,
  input  logic [GAP_WIDTH-1:0]       cfg_gap,
  input  logic [BURST_LEN_WIDTH-1:0] cfg_len,
  input  logic [TID_WIDTH-1:0]       cfg_id,
  input  logic [LOG_MAX_OUT-1:0]     cfg_max_out,
  output logic                       m_ar_valid,
  input  logic                       m_ar_ready,
  output logic [ADDR_BITS-1:0]       m_ar_addr,
  output logic [BURST_LEN_WIDTH-1:0] m_ar_len,
  output logic [TID_WIDTH-1:0]       m_ar_id,
  input  logic                       m_r_valid,
  output logic                       m_r_ready,
  input  logic                       m_r_last,
  input  logic [TID_WIDTH-1:0]       m_r_id,
  output logic                       busy,
  output logic                       done,
  output logic                       err_id,
  output logic                       err_unexp,
  output logic [LOG_MAX_OUT-1:0]     outstanding,
  output logic [CYC_WIDTH-1:0]       run_cycles
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  localparam logic [LOG_MAX_OUT-1:0] OUT_ZERO = {LOG_MAX_OUT{1'b0}};
  localparam logic [LOG_MAX_OUT-1:0] OUT_ONE  = {{(LOG_MAX_OUT-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]   CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]   CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [GAP_WIDTH-1:0]   GAP_ZERO = {GAP_WIDTH{1'b0}};
  localparam logic [GAP_WIDTH-1:0]   GAP_ONE  = {{(GAP_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CYC_WIDTH-1:0]   CYC_ZERO = {CYC_WIDTH{1'b0}};
  localparam logic [CYC_WIDTH-1:0]   CYC_ONE  = {{(CYC_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CYC_WIDTH-1:0]   CYC_MAX  = {CYC_WIDTH{1'b1}};

  logic [2:0]                 state_r;
  logic [2:0]                 state_nx_s;
  logic [ADDR_BITS-1:0]       addr_r;
  logic [ADDR_BITS-1:0]       stride_r;
  logic [CNT_WIDTH-1:0]       count_r;
  logic [CNT_WIDTH-1:0]       issued_r;
  logic [CNT_WIDTH-1:0]       issued_inc_s;
  logic [GAP_WIDTH-1:0]       gap_r;
  logic [GAP_WIDTH-1:0]       gap_cnt_r;
  logic [BURST_LEN_WIDTH-1:0] len_r;
  logic [TID_WIDTH-1:0]       id_r;
  logic [LOG_MAX_OUT-1:0]     max_out_r;
  logic [LOG_MAX_OUT-1:0]     max_sel_s;
  logic [LOG_MAX_OUT-1:0]     lim_s;
  logic [LOG_MAX_OUT-1:0]     out_r;
  logic [LOG_MAX_OUT-1:0]     out_nx_s;
  logic                       ar_valid_r;
  logic                       r_ready_r;
  logic                       busy_r;
  logic                       done_r;
  logic                       err_id_r;
  logic                       err_unexp_r;
  logic [CYC_WIDTH-1:0]       run_cycles_r;
  logic                       start_acc_s;
  logic                       ar_hs_s;
  logic                       beat_s;
  logic                       last_hs_s;

  assign start_acc_s  = (state_r == S_IDLE) && start;
  assign ar_hs_s      = ar_valid_r && m_ar_ready;
  assign beat_s       = m_r_valid && r_ready_r;
  assign last_hs_s    = beat_s && m_r_last;
  assign issued_inc_s = issued_r + CNT_ONE;

  // Outstanding-burst count after this cycle's AR and R-last handshakes; never underflows.
  always_comb begin
    out_nx_s = out_r;
    if (ar_hs_s && !last_hs_s) begin
      out_nx_s = out_r + OUT_ONE;
    end else if (last_hs_s && !ar_hs_s && (out_r != OUT_ZERO)) begin
      out_nx_s = out_r - OUT_ONE;
    end else begin
      out_nx_s = out_r;
    end
  end

  // Effective outstanding limit; the incoming config applies on the accepting cycle.
  always_comb begin
    max_sel_s = start_acc_s ? cfg_max_out : max_out_r;
    if (max_sel_s == OUT_ZERO) begin
      lim_s = OUT_ONE;
    end else begin
      lim_s = max_sel_s;
    end
  end

  // Run sequencing: IDLE -> ISSUE <-> GAP -> DRAIN -> FIN -> IDLE.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_nx_s = (cfg_count == CNT_ZERO) ? S_FIN : S_ISSUE;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (ar_hs_s) begin
          if (issued_inc_s == count_r) begin
            state_nx_s = S_DRAIN;
          end else if (gap_r == GAP_ZERO) begin
            state_nx_s = S_ISSUE;
          end else begin
            state_nx_s = S_GAP;
          end
        end else begin
          state_nx_s = S_ISSUE;
        end
      end
      S_GAP: begin
        // gap_cnt_r was loaded with cfg_gap on the handshake, so this gives exactly cfg_gap idle cycles.
        if (gap_cnt_r <= GAP_ONE) begin
          state_nx_s = S_ISSUE;
        end else begin
          state_nx_s = S_GAP;
        end
      end
      S_DRAIN: begin
        if (out_r == OUT_ZERO) begin
          state_nx_s = S_FIN;
        end else begin
          state_nx_s = S_DRAIN;
        end
      end
      S_FIN:   state_nx_s = S_IDLE;
      default: state_nx_s = S_IDLE;
    endcase
  end

  // State, configuration latch and request address/issue bookkeeping.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r   <= S_IDLE;
      addr_r    <= {ADDR_BITS{1'b0}};
      stride_r  <= {ADDR_BITS{1'b0}};
      count_r   <= CNT_ZERO;
      issued_r  <= CNT_ZERO;
      gap_r     <= GAP_ZERO;
      len_r     <= {BURST_LEN_WIDTH{1'b0}};
      id_r      <= {TID_WIDTH{1'b0}};
      max_out_r <= OUT_ZERO;
    end else begin
      state_r <= state_nx_s;
      if (start_acc_s) begin
        addr_r    <= cfg_base;
        stride_r  <= cfg_stride;
        count_r   <= cfg_count;
        issued_r  <= CNT_ZERO;
        gap_r     <= cfg_gap;
        len_r     <= cfg_len;
        id_r      <= cfg_id;
        max_out_r <= cfg_max_out;
      end else if (ar_hs_s) begin
        // Wraps modulo 2^ADDR_BITS; a stride with the MSB set walks downwards.
        addr_r   <= addr_r + stride_r;
        issued_r <= issued_inc_s;
      end
    end
  end

  // Inter-request idle counter.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      gap_cnt_r <= GAP_ZERO;
    end else if (ar_hs_s) begin
      gap_cnt_r <= gap_r;
    end else if (state_r == S_GAP) begin
      gap_cnt_r <= gap_cnt_r - GAP_ONE;
    end
  end

  // Outstanding counter and saturating run-cycle counter.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      out_r        <= OUT_ZERO;
      run_cycles_r <= CYC_ZERO;
    end else begin
      out_r <= out_nx_s;
      if (start_acc_s) begin
        run_cycles_r <= CYC_ZERO;
      end else if (((state_r == S_ISSUE) || (state_r == S_GAP) || (state_r == S_DRAIN)) &&
                   (run_cycles_r != CYC_MAX)) begin
        run_cycles_r <= run_cycles_r + CYC_ONE;
      end
    end
  end

  // Registered handshake/status outputs. ar_valid only rises in ISSUE under the limit;
  // outstanding can only fall while it waits, so it is never retracted before ready.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      ar_valid_r <= 1'b0;
      r_ready_r  <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      ar_valid_r <= (state_nx_s == S_ISSUE) && (out_nx_s < lim_s);
      r_ready_r  <= 1'b1;
      busy_r     <= (state_nx_s != S_IDLE);
      done_r     <= (state_nx_s == S_FIN);
    end
  end

  // Sticky R-channel anomaly flags, cleared when a new run is accepted.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      err_id_r    <= 1'b0;
      err_unexp_r <= 1'b0;
    end else begin
      err_id_r    <= (start_acc_s ? 1'b0 : err_id_r) | (beat_s && (m_r_id != id_r));
      err_unexp_r <= (start_acc_s ? 1'b0 : err_unexp_r) | (beat_s && (out_r == OUT_ZERO));
    end
  end

  assign m_ar_valid  = ar_valid_r;
  assign m_ar_addr   = addr_r;
  assign m_ar_len    = len_r;
  assign m_ar_id     = id_r;
  assign m_r_ready   = r_ready_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign err_id      = err_id_r;
  assign err_unexp   = err_unexp_r;
  assign outstanding = out_r;
  assign run_cycles  = run_cycles_r;

endmodule

// File: tb/tb_axi_stride_reader.sv
// Bench for axi_stride_reader: a cycle-indexed behavioural model (run timeline,
// address arithmetic, outstanding bookkeeping) checked every cycle, plus
// directed scenarios with literal expectations and randomized runs.
module tb_axi_stride_reader;

  logic        clk = 1'b0;
  logic        resetN;
  logic        start;
  logic [15:0] cfg_base, cfg_stride;
  logic [7:0]  cfg_count, cfg_gap, cfg_len, cfg_id;
  logic [2:0]  cfg_max_out;
  logic        m_ar_valid, m_ar_ready;
  logic [15:0] m_ar_addr;
  logic [7:0]  m_ar_len, m_ar_id;
  logic        m_r_valid, m_r_ready, m_r_last;
  logic [7:0]  m_r_id;
  logic        busy, done, err_id, err_unexp;
  logic [2:0]  outstanding;
  logic [23:0] run_cycles;

  always #5 clk = ~clk;

  axi_stride_reader dut (
    .clk(clk), .resetN(resetN), .start(start),
    .cfg_base(cfg_base), .cfg_stride(cfg_stride), .cfg_count(cfg_count),
    .cfg_gap(cfg_gap), .cfg_len(cfg_len), .cfg_id(cfg_id), .cfg_max_out(cfg_max_out),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
    .m_ar_len(m_ar_len), .m_ar_id(m_ar_id),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_last(m_r_last), .m_r_id(m_r_id),
    .busy(busy), .done(done), .err_id(err_id), .err_unexp(err_unexp),
    .outstanding(outstanding), .run_cycles(run_cycles)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  // model state
  bit          m_run, m_eid, m_eun, m_rr;
  int          m_s0, m_done_cyc, m_last_hs, m_issued, m_cnt, m_gap, m_lim, m_earliest, m_out, m_rc_hold;
  logic [15:0] m_base, m_stride;
  logic [7:0]  m_len, m_id;
  int          burst_q[$];
  logic [15:0] hs_log[$];
  int          hs_cyc[$];
  int          last_cycles[$];
  int          done_cnt;

  // stimulus knobs
  int          ready_mode;
  bit          r_en, start_req, bad_id_req, unexp_req;
  logic [15:0] w_base, w_stride;
  logic [7:0]  w_count, w_gap, w_len, w_id;
  logic [2:0]  w_max;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_reset();
    m_run = 0; m_eid = 0; m_eun = 0; m_rr = 0;
    m_s0 = 0; m_done_cyc = -1; m_last_hs = -1; m_issued = 0; m_cnt = 0; m_gap = 0;
    m_lim = 1; m_earliest = 0; m_out = 0; m_rc_hold = 0;
    m_base = 0; m_stride = 0; m_len = 0; m_id = 0;
    burst_q.delete();
  endtask

  // One clock cycle: compare outputs with the model, drive inputs, advance the model.
  task automatic step();
    logic        exp_valid, exp_done, hs, beat, lst, inj, sacc;
    logic [15:0] exp_addr;
    int          k, exp_rc;
    @(negedge clk);
    cyc++;
    k = cyc;
    if (!resetN) begin
      chk("rst_ar_valid", m_ar_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_outstanding", outstanding, 0);
      chk("rst_r_ready", m_r_ready, 0);
      chk("rst_run_cycles", run_cycles, 0);
      model_reset();
      start = 0; m_r_valid = 0; m_r_last = 0; m_ar_ready = 0;
      return;
    end
    if (m_run && m_cnt > 0 && m_issued == m_cnt && k > m_last_hs && m_out == 0 && m_done_cyc < 0)
      m_done_cyc = k + 1;
    exp_valid = m_run && (m_issued < m_cnt) && (k >= m_earliest) && (m_out < m_lim);
    exp_done  = m_run && (k == m_done_cyc);
    if (!m_run) exp_rc = m_rc_hold;
    else if (m_done_cyc >= 0 && k >= m_done_cyc) exp_rc = m_done_cyc - 1 - m_s0;
    else exp_rc = k - 1 - m_s0;
    exp_addr = m_base + 16'(m_issued) * m_stride;
    chk("ar_valid", m_ar_valid, exp_valid);
    chk("busy", busy, m_run);
    chk("done", done, exp_done);
    chk("outstanding", outstanding, m_out);
    chk("err_id", err_id, m_eid);
    chk("err_unexp", err_unexp, m_eun);
    chk("r_ready", m_r_ready, m_rr);
    chk("run_cycles", run_cycles, exp_rc);
    if (exp_valid && m_ar_valid) begin
      chk("ar_addr", m_ar_addr, exp_addr);
      chk("ar_len", m_ar_len, m_len);
      chk("ar_id", m_ar_id, m_id);
    end
    if (done) done_cnt++;
    // drive
    case (ready_mode)
      0:       m_ar_ready = 1'b1;
      1:       m_ar_ready = 1'($urandom_range(0, 1));
      default: m_ar_ready = 1'b0;
    endcase
    m_r_valid = 0; m_r_last = 0; m_r_id = m_id; inj = 0;
    if (m_rr) begin
      if (unexp_req) begin
        m_r_valid = 1; m_r_last = 1; inj = 1; unexp_req = 0;
      end else if (r_en && burst_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        m_r_valid = 1;
        m_r_last = (burst_q[0] == 1);
        if (bad_id_req) begin m_r_id = m_id + 8'd1; bad_id_req = 0; end
      end
    end
    sacc = 0;
    if (!m_run && start_req) begin
      start = 1; sacc = 1; start_req = 0;
      cfg_base = w_base; cfg_stride = w_stride; cfg_count = w_count; cfg_gap = w_gap;
      cfg_len = w_len; cfg_id = w_id; cfg_max_out = w_max;
    end else begin
      start = m_run && ($urandom_range(0, 7) == 0);
      cfg_base = 16'($urandom); cfg_stride = 16'($urandom); cfg_count = 8'($urandom);
      cfg_gap = 8'($urandom); cfg_len = 8'($urandom); cfg_id = 8'($urandom);
      cfg_max_out = 3'($urandom);
    end
    // advance model to the next edge
    hs   = exp_valid && m_ar_ready;
    beat = m_r_valid && m_rr;
    lst  = beat && m_r_last;
    if (lst) last_cycles.push_back(k);
    if (sacc) begin m_eid = 0; m_eun = 0; end
    if (beat && m_r_id != m_id) m_eid = 1;
    if (beat && m_out == 0) m_eun = 1;
    if (beat && !inj) begin
      burst_q[0] = burst_q[0] - 1;
      if (burst_q[0] == 0) void'(burst_q.pop_front());
    end
    if (hs && !lst) m_out++;
    else if (lst && !hs && m_out > 0) m_out--;
    if (hs) begin
      hs_log.push_back(exp_addr);
      hs_cyc.push_back(k);
      burst_q.push_back(int'(m_len) + 1);
      m_issued++;
      m_earliest = k + 1 + m_gap;
      if (m_issued == m_cnt) m_last_hs = k;
    end
    if (m_run && k == m_done_cyc) begin
      m_run = 0;
      m_rc_hold = m_done_cyc - 1 - m_s0;
    end
    if (sacc) begin
      m_base = w_base; m_stride = w_stride; m_cnt = w_count; m_gap = w_gap;
      m_len = w_len; m_id = w_id; m_lim = (w_max == 0) ? 1 : int'(w_max);
      m_issued = 0; m_s0 = k; m_run = 1; m_earliest = k + 1; m_last_hs = -1;
      m_done_cyc = (w_count == 0) ? k + 1 : -1;
    end
    m_rr = 1;
  endtask

  task automatic start_run(input logic [15:0] b, input logic [15:0] s, input logic [7:0] c,
                           input logic [7:0] g, input logic [7:0] l, input logic [7:0] id,
                           input logic [2:0] mx);
    w_base = b; w_stride = s; w_count = c; w_gap = g; w_len = l; w_id = id; w_max = mx;
    hs_log.delete(); hs_cyc.delete(); last_cycles.delete(); done_cnt = 0;
    start_req = 1;
    step();
  endtask

  task automatic run_to_idle(input int budget);
    int n = 0;
    while ((m_run || start_req) && n < budget) begin step(); n++; end
    if (m_run) chk("run_timeout", 1, 0);
    step(); step();
  endtask

  initial begin
    int n;
    int hi;
    resetN = 0; start = 0; m_ar_ready = 0; m_r_valid = 0; m_r_last = 0; m_r_id = 0;
    cfg_base = 0; cfg_stride = 0; cfg_count = 0; cfg_gap = 0; cfg_len = 0; cfg_id = 0; cfg_max_out = 0;
    ready_mode = 0; r_en = 1; start_req = 0; bad_id_req = 0; unexp_req = 0;
    model_reset();
    repeat (3) step();
    @(posedge clk); #1 resetN = 1;
    step();

    // back-to-back strided run
    start_run(16'h5940, 16'd3, 8'd4, 8'd0, 8'd0, 8'd5, 3'd7);
    run_to_idle(200);
    chk("t1_addr0", hs_log[0], 16'h5940);
    chk("t1_addr1", hs_log[1], 16'h5943);
    chk("t1_addr2", hs_log[2], 16'h5946);
    chk("t1_addr3", hs_log[3], 16'h5949);
    chk("t1_back_to_back", hs_cyc[3] - hs_cyc[0], 3);
    chk("t1_done_once", done_cnt, 1);
    chk("t1_out_end", outstanding, 0);

    // five idle cycles between handshakes
    start_run(16'h1000, 16'h0010, 8'd3, 8'd5, 8'd0, 8'd5, 3'd7);
    run_to_idle(300);
    chk("t2_gap01", hs_cyc[1] - hs_cyc[0], 6);
    chk("t2_gap12", hs_cyc[2] - hs_cyc[1], 6);

    // outstanding limit with R withheld, then release
    r_en = 0;
    start_run(16'h2000, 16'h0040, 8'd4, 8'd0, 8'd1, 8'd5, 3'd2);
    repeat (20) step();
    chk("t3_issued", hs_log.size(), 2);
    chk("t3_outstanding", outstanding, 2);
    chk("t3_valid_low", m_ar_valid, 0);
    last_cycles.delete();
    r_en = 1;
    run_to_idle(300);
    if (last_cycles.size() > 0) chk("t3_third_ar", hs_cyc[2] - last_cycles[0], 1);
    else chk("t3_rlast_seen", 0, 1);

    // ready withheld for four cycles
    ready_mode = 2;
    start_run(16'h3A00, 16'h0004, 8'd2, 8'd0, 8'd3, 8'd9, 3'd7);
    hi = 0;
    repeat (4) begin
      step();
      if (m_ar_valid && m_ar_addr == 16'h3A00 && m_ar_len == 8'd3 && m_ar_id == 8'd9) hi++;
    end
    chk("t4_stable", hi, 4);
    ready_mode = 0;
    run_to_idle(200);

    // address wrap and negative stride
    start_run(16'hFFFE, 16'd3, 8'd2, 8'd0, 8'd0, 8'd5, 3'd7);
    run_to_idle(200);
    chk("t5_wrap0", hs_log[0], 16'hFFFE);
    chk("t5_wrap1", hs_log[1], 16'h0001);
    start_run(16'h0002, 16'hFFFF, 8'd2, 8'd0, 8'd0, 8'd5, 3'd7);
    run_to_idle(200);
    chk("t5_neg0", hs_log[0], 16'h0002);
    chk("t5_neg1", hs_log[1], 16'h0001);

    // wrong R id is sticky; R-last while idle is unexpected
    bad_id_req = 1;
    start_run(16'h4000, 16'h0020, 8'd2, 8'd0, 8'd0, 8'd5, 3'd3);
    run_to_idle(200);
    repeat (3) step();
    chk("t6_err_id", err_id, 1);
    unexp_req = 1;
    repeat (2) step();
    chk("t6_err_unexp", err_unexp, 1);
    chk("t6_out_zero", outstanding, 0);

    // zero-count run completes immediately
    start_run(16'h0100, 16'h0001, 8'd0, 8'd0, 8'd0, 8'd1, 3'd1);
    run_to_idle(20);
    chk("t7_done", done_cnt, 1);
    chk("t7_run_cycles", run_cycles, 0);

    // randomized runs
    ready_mode = 1;
    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(0, 3) == 0) bad_id_req = 1;
      start_run(16'($urandom), 16'($urandom), 8'($urandom_range(0, 6)), 8'($urandom_range(0, 3)),
                8'($urandom_range(0, 3)), 8'($urandom), 3'($urandom));
      run_to_idle(2000);
    end

    // reset in the middle of issuing
    start_run(16'h7000, 16'h0008, 8'd6, 8'd2, 8'd1, 8'd3, 3'd1);
    n = 0;
    while (!m_ar_valid && n < 20) begin step(); n++; end
    chk("t8_valid_seen", m_ar_valid, 1);
    #2 resetN = 0;
    #1;
    chk("t8_async_valid", m_ar_valid, 0);
    chk("t8_async_busy", busy, 0);
    chk("t8_async_out", outstanding, 0);
    repeat (3) step();
    @(posedge clk); #1 resetN = 1;
    repeat (5) step();
    chk("t8_no_done", done_cnt, 0);
    ready_mode = 0;
    start_run(16'h0040, 16'h0002, 8'd3, 8'd1, 8'd0, 8'd2, 3'd0);
    run_to_idle(300);
    chk("t8_after_reset_done", done_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
